alu_issue_ctrl: RTL and testbench

- Multi-cycle issue controller that drives the team's 32-bit combinational ALU (ops AND/OR/XOR/NOR/ADD/SUB/SLT/SHL).
- Accepts MIPS R-type instruction words over a valid/ready handshake and decodes funct into the 3-bit ALU op.
- Reads operands from an internal 32x32 register file, drives the ALU, captures F/ZF/OF, and writes the result back to rd.
- Sits between the instruction source (fetch stage or testbench) and the ALU instance.

---
 rtl/alu_issue_ctrl_pkg.sv | 76 +++++++
 rtl/alu_regfile.sv | 42 ++++
 rtl/alu_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants and types for the ALU issue controller slice:
// ALU op codes, R-type funct/opcode values, FSM state encoding,
// the R-type instruction layout and the funct decoder.
package alu_issue_ctrl_pkg;

    localparam int unsigned REG_AW = 5;

    // ALU operation select
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_SHL = 3'b111;

    // R-type funct field values
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SHL = 6'b000100;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } r_inst_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] op;
    } dec_t;

    // Map opcode/funct to an ALU op; anything unrecognised is illegal
    function automatic dec_t decode_rtype(input logic [5:0] opcode, input logic [5:0] funct);
        dec_t d;
        d.legal = 1'b1;
        d.op    = ALU_AND;
        case (funct)
            FN_ADD:  d.op = ALU_ADD;
            FN_SUB:  d.op = ALU_SUB;
            FN_AND:  d.op = ALU_AND;
            FN_OR:   d.op = ALU_OR;
            FN_XOR:  d.op = ALU_XOR;
            FN_NOR:  d.op = ALU_NOR;
            FN_SLT:  d.op = ALU_SLT;
            FN_SHL:  d.op = ALU_SHL;
            default: d.legal = 1'b0;
        endcase
        if (opcode != OPC_RTYPE) begin
            d.legal = 1'b0;
        end
        if (!d.legal) begin
            d.op = ALU_AND;
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREG x DW, async active-high reset, one write port,
// two operand read ports and a debug read port. Register 0 reads as
// zero and ignores writes.
// Ports: clk, rst; we/waddr/wdata write port; ra_addr/ra_data and
// rb_addr/rb_data operand reads; dbg_addr/dbg_data debug read.
module alu_regfile
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DW-1:0]     ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DW-1:0]     rb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DW-1:0]     dbg_data
);

    logic [DW-1:0] regs [NREG];

    // Storage; writes to index 0 are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the external 32-bit ALU. Accepts an
// R-type word on INST_VALID/INST_READY, reads rs/rt from the internal
// register file, drives ALU_A/ALU_B/ALU_OP, captures ALU_F/ZF/OF and
// writes the result back to rd. One instruction every 4 cycles.
// Ports: clk, rst; INST_VALID/INST/INST_READY handshake; LD_EN/LD_ADDR/
// LD_DATA preload (IDLE only); ALU_A/ALU_B/ALU_OP to ALU; ALU_F/ALU_ZF/
// ALU_OF from ALU; DONE/ERR completion pulse; ZF/OF sticky flags;
// DBG_ADDR/DBG_DATA combinational register read.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              INST_VALID,
    input  logic [31:0]       INST,
    output logic              INST_READY,
    input  logic              LD_EN,
    input  logic [REG_AW-1:0] LD_ADDR,
    input  logic [DW-1:0]     LD_DATA,
    output logic [DW-1:0]     ALU_A,
    output logic [DW-1:0]     ALU_B,
    output logic [2:0]        ALU_OP,
    input  logic [DW-1:0]     ALU_F,
    input  logic              ALU_ZF,
    input  logic              ALU_OF,
    output logic              DONE,
    output logic              ERR,
    output logic              ZF,
    output logic              OF,
    input  logic [REG_AW-1:0] DBG_ADDR,
    output logic [DW-1:0]     DBG_DATA
);

    state_t        state;
    r_inst_t       inst_q;
    logic          illegal_q;
    logic [DW-1:0] f_q;
    logic          zf_q;
    logic          of_q;

    dec_t              dec;
    logic [DW-1:0]     rs_data;
    logic [DW-1:0]     rt_data;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic              unused_shamt;

    assign dec          = decode_rtype(inst_q.opcode, inst_q.funct);
    assign unused_shamt = ^inst_q.shamt;

    // Single write port shared by preload (IDLE) and write-back (WB)
    assign rf_we    = ((state == IDLE) && LD_EN) || ((state == WB) && !illegal_q);
    assign rf_waddr = (state == IDLE) ? LD_ADDR : inst_q.rd;
    assign rf_wdata = (state == IDLE) ? LD_DATA : f_q;

    alu_regfile #(
        .NREG (NREG),
        .DW   (DW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .ra_addr  (inst_q.rs),
        .ra_data  (rs_data),
        .rb_addr  (inst_q.rt),
        .rb_data  (rt_data),
        .dbg_addr (DBG_ADDR),
        .dbg_data (DBG_DATA)
    );

    // Issue FSM with registered outputs; DONE/ERR default low each cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            inst_q     <= '0;
            illegal_q  <= 1'b0;
            f_q        <= '0;
            zf_q       <= 1'b0;
            of_q       <= 1'b0;
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_OP     <= ALU_AND;
            INST_READY <= 1'b1;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            ZF         <= 1'b0;
            OF         <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (INST_VALID && INST_READY) begin
                        inst_q     <= r_inst_t'(INST);
                        INST_READY <= 1'b0;
                        state      <= DECODE;
                    end
                end
                DECODE: begin
                    ALU_A     <= rs_data;
                    ALU_B     <= rt_data;
                    ALU_OP    <= dec.op;
                    illegal_q <= !dec.legal;
                    state     <= EXEC;
                end
                EXEC: begin
                    f_q   <= ALU_F;
                    zf_q  <= ALU_ZF;
                    of_q  <= ALU_OF;
                    state <= WB;
                end
                WB: begin
                    if (!illegal_q) begin
                        ZF <= zf_q;
                        OF <= of_q;
                    end
                    DONE       <= 1'b1;
                    ERR        <= illegal_q;
                    INST_READY <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the ALU.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_f;
    logic        alu_zf;
    logic        alu_of;
    logic        done;
    logic        err;
    logic        zf;
    logic        of;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .INST_VALID (inst_valid),
        .INST       (inst),
        .INST_READY (inst_ready),
        .LD_EN      (ld_en),
        .LD_ADDR    (ld_addr),
        .LD_DATA    (ld_data),
        .ALU_A      (alu_a),
        .ALU_B      (alu_b),
        .ALU_OP     (alu_op),
        .ALU_F      (alu_f),
        .ALU_ZF     (alu_zf),
        .ALU_OF     (alu_of),
        .DONE       (done),
        .ERR        (err),
        .ZF         (zf),
        .OF         (of),
        .DBG_ADDR   (dbg_addr),
        .DBG_DATA   (dbg_data)
    );

    // ALU model: OF is carry-out for ADD, borrow for SUB
    always_comb begin
        alu_f  = '0;
        alu_of = 1'b0;
        case (alu_op)
            3'b000: alu_f = alu_a & alu_b;
            3'b001: alu_f = alu_a | alu_b;
            3'b010: alu_f = alu_a ^ alu_b;
            3'b011: alu_f = ~(alu_a | alu_b);
            3'b100: {alu_of, alu_f} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b101: begin
                alu_f  = alu_a - alu_b;
                alu_of = (alu_a < alu_b);
            end
            3'b110: alu_f = {31'd0, (alu_a < alu_b)};
            default: alu_f = alu_a << alu_b[4:0];
        endcase
    end
    assign alu_zf = (alu_f == '0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick;
        ld_en   = 1'b0;
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rdi,
                                          input logic [5:0] fn);
        return {opc, rs, rt, rdi, 5'd0, fn};
    endfunction

    // Present one word, then wait (bounded) for DONE; lat counts edges after accept
    task automatic issue(input logic [31:0] w, output logic [2:0] op_seen, output int lat);
        inst       = w;
        inst_valid = 1'b1;
        tick;
        inst_valid = 1'b0;
        ld_en      = 1'b0;
        check("ready_low_decode", 32'(inst_ready), 32'd0);
        tick;
        lat     = 1;
        op_seen = alu_op;
        while (!done && lat < 8) begin
            tick;
            lat++;
        end
    endtask

    logic [31:0] v;
    logic [2:0]  op;
    int          lat;
    int          hs_cnt;
    int          hs_last;
    int          hs_first;
    int          rdy_zero;
    int          done_cnt;
    logic        hs;

    initial begin
        rst        = 1'b1;
        inst_valid = 1'b0;
        inst       = '0;
        ld_en      = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        dbg_addr   = '0;
        tick;
        tick;
        rst = 1'b0;
        tick;

        // Reset state
        check("rst_ready", 32'(inst_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_zf_of", 32'({zf, of, err}), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        rd_reg(5'd5, v);
        check("rst_r5", v, 32'd0);

        // ADD r3 = r1 + r2
        preload(5'd1, 32'h0000000F);
        preload(5'd2, 32'h000000F0);
        issue(rtype(6'd0, 5'd1, 5'd2, 5'd3, 6'b100000), op, lat);
        check("add_latency", 32'(lat), 32'd3);
        check("add_op", 32'(op), 32'd4);
        rd_reg(5'd3, v);
        check("add_r3", v, 32'h000000FF);
        check("add_flags", 32'({err, zf, of}), 32'd0);
        tick;
        check("done_pulse_one", 32'(done), 32'd0);

        // ADD with carry-out: r4 = 0, ZF=1, OF=1
        preload(5'd1, 32'hFFFFFFFF);
        preload(5'd2, 32'h00000001);
        issue(rtype(6'd0, 5'd1, 5'd2, 5'd4, 6'b100000), op, lat);
        rd_reg(5'd4, v);
        check("carry_r4", v, 32'h00000000);
        check("carry_zf", 32'(zf), 32'd1);
        check("carry_of", 32'(of), 32'd1);

        // Illegal opcode: ERR, no write, flags unchanged
        issue(rtype(6'b000010, 5'd1, 5'd2, 5'd7, 6'b100000), op, lat);
        check("badopc_done_err", 32'({done, err}), 32'd3);
        check("badopc_latency", 32'(lat), 32'd3);
        check("badopc_op", 32'(op), 32'd0);
        rd_reg(5'd7, v);
        check("badopc_r7", v, 32'd0);
        check("badopc_flags", 32'({zf, of}), 32'd3);

        // Illegal funct targeting r1
        issue(rtype(6'd0, 5'd1, 5'd2, 5'd1, 6'b111111), op, lat);
        check("badfn_done_err", 32'({done, err}), 32'd3);
        rd_reg(5'd1, v);
        check("badfn_r1", v, 32'hFFFFFFFF);
        check("badfn_flags", 32'({zf, of}), 32'd3);

        // SUB r5 = r5 - r5
        preload(5'd5, 32'h12345678);
        issue(rtype(6'd0, 5'd5, 5'd5, 5'd5, 6'b100010), op, lat);
        check("sub_op", 32'(op), 32'd5);
        rd_reg(5'd5, v);
        check("sub_r5", v, 32'd0);
        check("sub_flags", 32'({err, zf, of}), 32'b010);

        // SLT 3 < 7
        preload(5'd1, 32'd3);
        preload(5'd2, 32'd7);
        issue(rtype(6'd0, 5'd1, 5'd2, 5'd6, 6'b101010), op, lat);
        rd_reg(5'd6, v);
        check("slt_r6", v, 32'd1);
        check("slt_flags", 32'({zf, of}), 32'd0);

        // SHL r7 = 3 << 7
        issue(rtype(6'd0, 5'd1, 5'd2, 5'd7, 6'b000100), op, lat);
        rd_reg(5'd7, v);
        check("shl_r7", v, 32'h00000180);

        // OR into r0 is dropped; preload to r0 dropped too
        preload(5'd0, 32'hDEADBEEF);
        issue(rtype(6'd0, 5'd1, 5'd2, 5'd0, 6'b100101), op, lat);
        check("or_r0_err", 32'(err), 32'd0);
        rd_reg(5'd0, v);
        check("r0_zero", v, 32'd0);

        // Preload in the same cycle as accept: DECODE sees the new value
        ld_en   = 1'b1;
        ld_addr = 5'd8;
        ld_data = 32'h000000A5;
        issue(rtype(6'd0, 5'd8, 5'd0, 5'd9, 6'b100000), op, lat);
        rd_reg(5'd9, v);
        check("same_cycle_ld_r9", v, 32'h000000A5);

        // LD_EN while busy is ignored
        inst       = rtype(6'd0, 5'd1, 5'd2, 5'd14, 6'b100100);
        inst_valid = 1'b1;
        tick;
        inst_valid = 1'b0;
        ld_en      = 1'b1;
        ld_addr    = 5'd10;
        ld_data    = 32'h00000055;
        tick;
        tick;
        ld_en = 1'b0;
        lat = 0;
        while (!done && lat < 8) begin
            tick;
            lat++;
        end
        check("busy_ld_done", 32'(done), 32'd1);
        rd_reg(5'd10, v);
        check("busy_ld_r10", v, 32'd0);
        rd_reg(5'd14, v);
        check("busy_and_r14", v, 32'd3);
        tick;

        // Continuous INST_VALID: accepts exactly every 4 cycles
        inst       = rtype(6'd0, 5'd1, 5'd2, 5'd11, 6'b100111);
        inst_valid = 1'b1;
        hs_cnt   = 0;
        hs_last  = -1;
        hs_first = -1;
        rdy_zero = 0;
        for (int c = 0; c < 12; c++) begin
            hs = inst_ready;
            if (!inst_ready) rdy_zero++;
            tick;
            if (hs) begin
                if (hs_first < 0) hs_first = c;
                hs_cnt++;
                hs_last = c;
            end
        end
        inst_valid = 1'b0;
        check("b2b_accepts", 32'(hs_cnt), 32'd3);
        check("b2b_spacing", 32'(hs_last - hs_first), 32'd8);
        check("b2b_ready_low", 32'(rdy_zero), 32'd9);
        check("b2b_last_done", 32'(done), 32'd1);
        rd_reg(5'd11, v);
        check("b2b_nor_r11", v, 32'hFFFFFFF8);
        tick;

        // Reset during EXEC
        preload(5'd12, 32'h00000077);
        inst       = rtype(6'd0, 5'd12, 5'd12, 5'd13, 6'b100000);
        inst_valid = 1'b1;
        tick;
        inst_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rstmid_ready", 32'(inst_ready), 32'd1);
        check("rstmid_outs", 32'({done, err, zf, of}), 32'd0);
        rd_reg(5'd12, v);
        check("rstmid_r12", v, 32'd0);
        rd_reg(5'd1, v);
        check("rstmid_r1", v, 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (done) done_cnt++;
        end
        check("rstmid_no_done", 32'(done_cnt), 32'd0);
        rd_reg(5'd13, v);
        check("rstmid_r13", v, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
